// File: rtl/tile_scheduler_pkg.sv
// Shared types for the tile scheduler: FSM states and the per-tile geometry record.
package tile_pkg;
  localparam int DIM_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_OFFER, S_LAUNCH, S_WAIT, S_NEXT, S_FIN
  } state_e;

  typedef struct packed {
    logic signed [DIM_W:0] in_row;
    logic signed [DIM_W:0] in_col;
    logic [DIM_W-1:0]      in_h;
    logic [DIM_W-1:0]      in_w;
    logic [DIM_W-1:0]      out_row;
    logic [DIM_W-1:0]      out_col;
    logic [DIM_W-1:0]      out_h;
    logic [DIM_W-1:0]      out_w;
  } tile_geom_t;
endpackage

// File: rtl/tile_geom_calc.sv
// Maps an output-tile origin plus layer config to the clipped output tile and its input window.
module tile_geom_calc
  import tile_pkg::*;
(
  input  logic [DIM_W-1:0] row0_i,
  input  logic [DIM_W-1:0] col0_i,
  input  logic [DIM_W-1:0] out_h_i,
  input  logic [DIM_W-1:0] out_w_i,
  input  logic [DIM_W-1:0] tile_h_i,
  input  logic [DIM_W-1:0] tile_w_i,
  input  logic [3:0]       k_i,
  input  logic [1:0]       stride_i,
  input  logic [3:0]       pad_i,
  output tile_geom_t       geom_o
);
  logic [DIM_W-1:0] rem_h, rem_w, eff_h, eff_w;
  logic [DIM_W:0]   row_x, col_x;

  always_comb begin
    rem_h = out_h_i - row0_i;
    rem_w = out_w_i - col0_i;
    eff_h = (tile_h_i < rem_h) ? tile_h_i : rem_h;
    eff_w = (tile_w_i < rem_w) ? tile_w_i : rem_w;
    row_x = {1'b0, row0_i} * (DIM_W+1)'(stride_i);
    col_x = {1'b0, col0_i} * (DIM_W+1)'(stride_i);

    geom_o         = '0;
    // Padding can push the window origin above/left of the image, hence the sign bit.
    geom_o.in_row  = $signed(row_x - (DIM_W+1)'(pad_i));
    geom_o.in_col  = $signed(col_x - (DIM_W+1)'(pad_i));
    geom_o.in_h    = (eff_h - DIM_W'(1)) * DIM_W'(stride_i) + DIM_W'(k_i);
    geom_o.in_w    = (eff_w - DIM_W'(1)) * DIM_W'(stride_i) + DIM_W'(k_i);
    geom_o.out_row = row0_i;
    geom_o.out_col = col0_i;
    geom_o.out_h   = eff_h;
    geom_o.out_w   = eff_w;
  end
endmodule

// File: rtl/tile_scheduler.sv
// Walks output tiles in raster order, offers each tile's geometry, launches the reader and waits for it.
module tile_scheduler #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIM_W-1:0]        cfg_img_h,
  input  logic [DIM_W-1:0]        cfg_img_w,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [DIM_W-1:0]        cfg_out_h,
  input  logic [DIM_W-1:0]        cfg_out_w,
  input  logic [DIM_W-1:0]        cfg_tile_h,
  input  logic [DIM_W-1:0]        cfg_tile_w,
  input  logic [3:0]              cfg_k,
  input  logic [1:0]              cfg_stride,
  input  logic [3:0]              cfg_pad,
  output logic                    rd_start,
  output logic [DIM_W-1:0]        rd_img_h,
  output logic [DIM_W-1:0]        rd_img_w,
  output logic [ADDR_W-1:0]       rd_base_addr,
  output logic signed [DIM_W:0]   rd_tile_in_row,
  output logic signed [DIM_W:0]   rd_tile_in_col,
  output logic [DIM_W-1:0]        rd_tile_in_h,
  output logic [DIM_W-1:0]        rd_tile_in_w,
  input  logic                    rd_done,
  output logic                    tile_valid,
  input  logic                    tile_ready,
  output logic [DIM_W-1:0]        tile_out_row,
  output logic [DIM_W-1:0]        tile_out_col,
  output logic [DIM_W-1:0]        tile_out_h,
  output logic [DIM_W-1:0]        tile_out_w,
  output logic [DIM_W-1:0]        tile_idx,
  output logic                    busy,
  output logic                    done
);
  import tile_pkg::*;

  state_e            state_q;
  logic [DIM_W-1:0]  img_h_q, img_w_q, out_h_q, out_w_q, tile_h_q, tile_w_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        k_q, pad_q;
  logic [1:0]        stride_q;
  logic [DIM_W-1:0]  row0_q, col0_q, idx_q;
  tile_geom_t        geom_q, geom_d;
  logic              tile_valid_q, rd_start_q, done_q;
  logic [DIM_W:0]    row_sum, col_sum;
  logic              cfg_empty;

  tile_geom_calc u_calc (
    .row0_i   (row0_q),
    .col0_i   (col0_q),
    .out_h_i  (out_h_q),
    .out_w_i  (out_w_q),
    .tile_h_i (tile_h_q),
    .tile_w_i (tile_w_q),
    .k_i      (k_q),
    .stride_i (stride_q),
    .pad_i    (pad_q),
    .geom_o   (geom_d)
  );

  assign row_sum   = {1'b0, row0_q} + {1'b0, tile_h_q};
  assign col_sum   = {1'b0, col0_q} + {1'b0, tile_w_q};
  assign cfg_empty = (cfg_out_h == '0) || (cfg_out_w == '0) ||
                     (cfg_tile_h == '0) || (cfg_tile_w == '0);

  // tile_valid is held until tile_ready is seen high on a clock edge; geometry stays frozen until the reader finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      img_h_q      <= '0;  img_w_q  <= '0;  base_q   <= '0;
      out_h_q      <= '0;  out_w_q  <= '0;
      tile_h_q     <= '0;  tile_w_q <= '0;
      k_q          <= '0;  stride_q <= '0;  pad_q    <= '0;
      row0_q       <= '0;  col0_q   <= '0;  idx_q    <= '0;
      geom_q       <= '0;
      tile_valid_q <= 1'b0;
      rd_start_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          img_h_q  <= cfg_img_h;   img_w_q  <= cfg_img_w;   base_q <= cfg_base_addr;
          out_h_q  <= cfg_out_h;   out_w_q  <= cfg_out_w;
          tile_h_q <= cfg_tile_h;  tile_w_q <= cfg_tile_w;
          k_q      <= cfg_k;       stride_q <= cfg_stride;  pad_q  <= cfg_pad;
          row0_q   <= '0;          col0_q   <= '0;          idx_q  <= '0;
          if (cfg_empty) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          geom_q       <= geom_d;
          tile_valid_q <= 1'b1;
          state_q      <= S_OFFER;
        end
        S_OFFER: if (tile_ready) begin
          tile_valid_q <= 1'b0;
          rd_start_q   <= 1'b1;
          state_q      <= S_LAUNCH;
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT:   if (rd_done) state_q <= S_NEXT;
        S_NEXT: begin
          idx_q <= idx_q + DIM_W'(1);
          if (col_sum < {1'b0, out_w_q}) begin
            col0_q  <= col_sum[DIM_W-1:0];
            state_q <= S_CALC;
          end else begin
            col0_q <= '0;
            if (row_sum < {1'b0, out_h_q}) begin
              row0_q  <= row_sum[DIM_W-1:0];
              state_q <= S_CALC;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_start       = rd_start_q;
  assign rd_img_h       = img_h_q;
  assign rd_img_w       = img_w_q;
  assign rd_base_addr   = base_q;
  assign rd_tile_in_row = geom_q.in_row;
  assign rd_tile_in_col = geom_q.in_col;
  assign rd_tile_in_h   = geom_q.in_h;
  assign rd_tile_in_w   = geom_q.in_w;
  assign tile_valid     = tile_valid_q;
  assign tile_out_row   = geom_q.out_row;
  assign tile_out_col   = geom_q.out_col;
  assign tile_out_h     = geom_q.out_h;
  assign tile_out_w     = geom_q.out_w;
  assign tile_idx       = idx_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Sequences a tile reader across a whole feature map. It walks output tiles in raster order and converts each output tile into an input window, accounting for kernel size, stride and padding. For each tile it offers the geometry to the downstream compute stage, launches the tile reader, and waits for the reader's done. It raises busy while walking and pulses done after the last tile.

Parameters:
DIM_W, 16, width of image/tile dimensions
ADDR_W, 32, width of base address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a frame pass; ignored unless IDLE
cfg_img_h  in  DIM_W  input image height (passed through)
cfg_img_w  in  DIM_W  input image width (passed through)
cfg_base_addr  in  ADDR_W  input image base address (passed through)
cfg_out_h  in  DIM_W  output map height
cfg_out_w  in  DIM_W  output map width
cfg_tile_h  in  DIM_W  nominal output tile height
cfg_tile_w  in  DIM_W  nominal output tile width
cfg_k  in  4  kernel size, 1..15
cfg_stride  in  2  stride, 1..3
cfg_pad  in  4  padding, 0..15
rd_start  out  1  one-cycle launch pulse to the tile reader
rd_img_h, rd_img_w  out  DIM_W  latched image dimensions
rd_base_addr  out  ADDR_W  latched base address
rd_tile_in_row, rd_tile_in_col  out  DIM_W+1  signed input-window origin
rd_tile_in_h, rd_tile_in_w  out  DIM_W  input-window size
rd_done  in  1  tile reader finished the current tile
tile_valid  out  1  tile geometry offered to the consumer
tile_ready  in  1  consumer accepts the tile
tile_out_row, tile_out_col  out  DIM_W  output tile origin
tile_out_h, tile_out_w  out  DIM_W  effective output tile size
tile_idx  out  DIM_W  raster index of the current tile
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: all outputs 0, state IDLE, all registers cleared.
- States: IDLE, CALC, OFFER, LAUNCH, WAIT, NEXT, FIN.
- IDLE: on start, latch all cfg_*, set row0 = col0 = tile_idx = 0.
  - If cfg_out_h, cfg_out_w, cfg_tile_h or cfg_tile_w is 0, go to FIN; no tiles are issued.
  - Otherwise go to CALC.
- CALC (1 cycle): register the tile geometry.
  - eff_h = min(tile_h, out_h - row0); eff_w likewise for columns.
  - in_row = signed(row0*stride) - pad; in_col likewise. Both are DIM_W+1 signed.
  - in_h = (eff_h-1)*stride + k; in_w likewise. Truncate to DIM_W.
  - Go to OFFER.
- OFFER: tile_valid = 1.
  - All tile_* and rd_* geometry outputs stay stable from CALC until leaving WAIT.
  - On tile_valid && tile_ready, go to LAUNCH.
- LAUNCH: rd_start = 1 for exactly this cycle, then go to WAIT.
- WAIT: on rd_done, go to NEXT. rd_done in any other state is ignored.
- NEXT: advance the tile position and increment tile_idx.
  - If col0 + tile_w < out_w: col0 += tile_w, go to CALC.
  - Else col0 = 0. If row0 + tile_h < out_h: row0 += tile_h, go to CALC.
  - Else go to FIN.
  - Compare in DIM_W+1 bits so the sums do not wrap.
- FIN: done = 1 for one cycle, then go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored; the latched config is unchanged.
- Minimum per-tile overhead is 4 cycles (CALC, OFFER, LAUNCH, NEXT) plus reader time.
- Reset mid-operation aborts immediately to IDLE with outputs cleared; no done pulse.

Decomposition:
- Package tile_pkg holds:
  - the state enum type;
  - a tile_geom_t struct (in_row, in_col, in_h, in_w, out_row, out_col, out_h, out_w);
  - DIM_W as a default constant.
- One natural sub-module, tile_geom_calc: purely combinational mapping of (row0, col0, config) to tile_geom_t, registered in CALC.

Test Plan:
- out 8x8, tile 4x4, k=3, pad=1, stride=1, tile_ready tied 1, reader done 5 cycles after rd_start:
  - 4 tiles: (in_row, in_col) = (-1,-1), (-1,3), (3,-1), (3,3); all in_h = in_w = 6.
  - tile_idx runs 0..3; done pulses once; busy falls the cycle after done.
- out 5x5, tile 4x4, k=3, pad=1, stride=1:
  - tile 1 has out_w=1, in_col=3, in_w=3; tile 3 has out_h = out_w = 1, in_h = in_w = 3.
- Stride 2: out 4x4, tile 4x4, k=3, pad=1: single tile with in_row = in_col = -1, in_h = in_w = 9.
- Backpressure: hold tile_ready=0 for 10 cycles in OFFER.
  - tile_valid stays 1 with stable geometry; rd_start stays 0.
  - rd_start pulses exactly once after acceptance.
- Spurious events:
  - rd_done pulsed in OFFER is ignored.
  - start pulsed in WAIT is ignored; config unchanged.
  - cfg_tile_w=0 yields done 2 cycles after start with no rd_start.
- Assert rst_n low during WAIT of tile 2:
  - all outputs 0 and IDLE; no done pulse.
  - A subsequent start rescans from tile 0.
